// File: rtl/ysyx_220066_pkg.sv
// Shared definitions for the fetch controller: FSM encoding, reset PC and
// instruction width.
package ysyx_220066_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_REQ  = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_HOLD = 3'd3;
  localparam logic [2:0] ST_DROP = 3'd4;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    REQ  = ST_REQ,
    WAIT = ST_WAIT,
    HOLD = ST_HOLD,
    DROP = ST_DROP
  } fetch_state_e;

  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;
  localparam int          INST_W           = 32;

  // Redirect targets are forced onto a 4-byte boundary.
  function automatic logic [63:0] align_pc(input logic [63:0] pc);
    return {pc[63:2], 2'b00};
  endfunction

endpackage

// File: rtl/ysyx_220066_sat_cnt.sv
// Generic up-counter that sticks at all ones instead of wrapping.
module ysyx_220066_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc) begin
      count <= sat_inc(count);
    end
  end

endmodule

// File: rtl/ysyx_220066_fetch_ctrl.sv
// Fetch sequencer: owns the PC, keeps one IFU request in flight and holds the
// returned instruction for decode; redirects cancel in-flight work.
module ysyx_220066_fetch_ctrl
  import ysyx_220066_pkg::*;
#(
  parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [63:0]       redirect_pc,
  output logic              ifu_req_valid,
  output logic [63:0]       ifu_req_addr,
  input  logic              ifu_req_ready,
  input  logic              ifu_resp_valid,
  input  logic [INST_W-1:0] ifu_resp_data,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [63:0]       inst_pc,
  input  logic              inst_ready,
  output logic              misalign,
  output logic [CNT_W-1:0]  drop_cnt
);

  fetch_state_e state, state_nxt;
  logic [63:0]  pc, pc_nxt, target;
  logic         capture, drop_inc, redirect_taken;

  assign target         = align_pc(redirect_pc);
  assign redirect_taken = redirect_valid && (state != IDLE);

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    capture   = 1'b0;
    drop_inc  = 1'b0;
    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        if (redirect_valid) pc_nxt = target;
        // A redirect racing the handshake leaves a stale fetch to swallow.
        if (ifu_req_ready) state_nxt = redirect_valid ? DROP : WAIT;
      end
      WAIT: begin
        if (ifu_resp_valid && redirect_valid) begin
          drop_inc  = 1'b1;
          pc_nxt    = target;
          state_nxt = REQ;
        end else if (ifu_resp_valid) begin
          capture   = 1'b1;
          state_nxt = HOLD;
        end else if (redirect_valid) begin
          pc_nxt    = target;
          state_nxt = DROP;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_nxt    = target;
          state_nxt = REQ;
        end else if (inst_ready) begin
          pc_nxt    = pc + 64'd4;
          state_nxt = REQ;
        end
      end
      DROP: begin
        if (redirect_valid) pc_nxt = target;
        if (ifu_resp_valid) begin
          drop_inc  = 1'b1;
          state_nxt = REQ;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      inst     <= '0;
      inst_pc  <= '0;
      misalign <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      misalign <= redirect_taken && (redirect_pc[1:0] != 2'b00);
      if (capture) begin
        inst    <= ifu_resp_data;
        inst_pc <= pc;
      end
    end
  end

  ysyx_220066_sat_cnt #(
    .CNT_W(CNT_W)
  ) u_drop_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (drop_inc),
    .count(drop_cnt)
  );

  assign ifu_req_valid = (state == REQ);
  assign ifu_req_addr  = pc;
  assign inst_valid    = (state == HOLD);

endmodule
